mips_ex_muldiv: RTL and testbench
=================================

// Module: mips_ex_muldiv
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage, alongside the single-cycle ALU.
//  - Executes MULT/MULTU/DIV/DIVU over several cycles and owns the architectural HI/LO registers.
//  - Also executes MTHI/MTLO.
//  - EX/ID use busy/req_ready to stall MFHI/MFLO and later mul/div ops until the result commits.
// PARAMETERS
//  DATA_WIDTH     32  operand/HI/LO width (= `MIPS_DATA_WIDTH); must be even, >= 8
//  BITS_PER_CYCLE 1   quotient/multiplier bits retired per CALC cycle; one of 1,2,4; divides DATA_WIDTH
//  (derived) ITER = DATA_WIDTH/BITS_PER_CYCLE
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           synchronous, active-high reset
//  req_valid  in   1           request present
//  req_ready  out  1           unit can accept (state IDLE)
//  req_op     in   3           0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6-7 no-op
//  req_rs     in   DATA_WIDTH  operand A / dividend / MT source
//  req_rt     in   DATA_WIDTH  operand B / divisor
//  flush      in   1           abort in-flight op (branch/exception squash)
//  busy       out  1           state != IDLE
//  done       out  1           one-cycle pulse: HI/LO commit this cycle
//  hi         out  DATA_WIDTH  architectural HI
//  lo         out  DATA_WIDTH  architectural LO
// BEHAVIOUR
//  Reset: state=IDLE; hi=lo=0; done=0; busy=0; req_ready=1 from the first cycle after reset; counter=0.
//  Handshake: accept = req_valid & req_ready & ~flush, sampled at the rising edge.
//  FSM IDLE -> CALC -> FIN -> IDLE.
//  - IDLE, accept, op 0-3: latch |rs|,|rt| (abs only for signed ops); latch result signs; cnt=ITER-1; -> CALC.
//  - IDLE, accept, op 4/5: hi (resp. lo) <= rs at that edge. Stay IDLE; no done. Ops 6/7 accepted, no effect.
//  - CALC: retire BITS_PER_CYCLE bits per cycle.
//    - Multiply: shift-add into a 2*DATA_WIDTH accumulator.
//    - Divide: restoring, non-performing.
//    - When cnt==0 -> FIN; otherwise cnt--.
//  - FIN: apply sign correction; done=1. {hi,lo} update at the end of FIN. -> IDLE.
//  Latency: accept at edge k. CALC occupies cycles k+1..k+ITER; done is high in cycle k+ITER+1.
//    New hi/lo are visible from cycle k+ITER+2. BITS_PER_CYCLE=1: done 33 cycles after accept.
//  Result rules (mod 2^DATA_WIDTH):
//    MULT/MULTU: {hi,lo} = full 2*DATA_WIDTH product.
//      Negated when sign(rs)^sign(rt) for MULT.
//    DIV/DIVU: lo=quotient, hi=remainder.
//      Signed DIV: quotient truncates toward zero; quotient negated when sign(rs)^sign(rt); remainder takes sign of rs.
//    Divide by zero (DIV, DIVU): lo = all ones, hi = rs. No exception, same latency.
//    DIV MIN/-1: lo = MIN (0x80000000), hi = 0. No exception.
//  req_ready=0 in CALC and FIN; requests there are ignored and must be held by the sender.
//    A request presented in FIN cycle is accepted on the next (IDLE) cycle.
//  flush: in CALC/FIN -> IDLE at that edge; hi/lo unchanged; done=0 that cycle (flush wins over FIN commit).
//    In IDLE, flush suppresses any simultaneous accept (MT ops included).
//  rst mid-operation overrides everything: same values as at reset, the in-flight op is lost.
//  hi/lo are registered outputs and change only at the FIN commit, at MT ops, or at rst.
// TESTING
//  1 BITS_PER_CYCLE=1, MULTU 0xFFFFFFFF*0xFFFFFFFF -> done 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001.
//  2 MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//    MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  3 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//    DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
//  4 MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, no done.
//    Then MULTU 0*0 is accepted; an MTLO issued in CALC sees req_ready=0 and leaves lo unchanged until it is accepted after FIN.
//  5 With hi/lo=0xA/0xB, start DIVU; assert flush in CALC cycle 10 -> busy=0 next cycle, done never pulses, hi/lo stay 0xA/0xB.
//    flush asserted in the FIN cycle -> no commit.
//  6 rst asserted mid-CALC -> next cycle hi=lo=0, busy=0, req_ready=1.
//    BITS_PER_CYCLE=4, DATA_WIDTH=32 -> done 9 cycles after accept; rerun cases 1-3 at BITS_PER_CYCLE=4 for identical results.

Source files
------------

// File: rtl/mips_ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; also executes MTHI/MTLO.
// Retires BITS_PER_CYCLE multiplier/quotient bits per CALC cycle, then commits HI/LO in FIN.
module mips_ex_muldiv #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_rs,
  input  logic [DATA_WIDTH-1:0] req_rt,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W    = DATA_WIDTH;
  localparam int ITER = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  // Handshake: a request transfers on a rising edge where req_valid & req_ready & ~flush;
  // req_ready is high only in IDLE, so senders hold requests through CALC/FIN.
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc, acc_step;
  logic [W-1:0]   opnd;
  logic           is_div, neg_q, neg_r, div0;
  logic           accept, start, signed_op;
  logic [W-1:0]   rs_abs, rt_abs;
  logic [W:0]     sum, shifted;
  logic [2*W-1:0] prod_fix;

  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;
  assign done      = (state == S_FIN) & ~flush;
  assign accept    = req_valid & req_ready & ~flush;
  assign start     = accept & ~req_op[2];
  assign signed_op = ~req_op[0];
  assign rs_abs    = (signed_op & req_rs[W-1]) ? -req_rs : req_rs;
  assign rt_abs    = (signed_op & req_rt[W-1]) ? -req_rt : req_rt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (flush) state_nxt = S_IDLE;
               else if (cnt == '0) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    acc_step = acc;
    sum      = '0;
    shifted  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        shifted = acc_step[2*W-1:W-1];
        if (shifted >= {1'b0, opnd}) begin
          shifted  = shifted - {1'b0, opnd};
          acc_step = {shifted[W-1:0], acc_step[W-2:0], 1'b1};
        end else begin
          acc_step = {shifted[W-1:0], acc_step[W-2:0], 1'b0};
        end
      end else begin
        sum      = {1'b0, acc_step[2*W-1:W]} + ({(W+1){acc_step[0]}} & {1'b0, opnd});
        acc_step = {sum, acc_step[W-1:1]};
      end
    end
  end

  assign prod_fix = neg_q ? -acc : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0; lo <= '0; acc <= '0; opnd <= '0; cnt <= '0;
      is_div <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; div0 <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (start) begin
            is_div <= req_op[1];
            neg_q  <= signed_op & (req_rs[W-1] ^ req_rt[W-1]);
            neg_r  <= signed_op & req_rs[W-1];
            div0   <= (req_rt == '0);
            cnt    <= CW'(ITER - 1);
            if (req_op[1]) begin
              opnd <= rt_abs;
              acc  <= {{W{1'b0}}, rs_abs};
            end else begin
              opnd <= rs_abs;
              acc  <= {{W{1'b0}}, rt_abs};
            end
          end else if (req_op == 3'd4) begin
            hi <= req_rs;
          end else if (req_op == 3'd5) begin
            lo <= req_rs;
          end
        end
        S_CALC: begin
          acc <= acc_step;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        S_FIN: if (!flush) begin
          if (is_div) begin
            // Divide by zero: the remainder path already yields rs; only the quotient is forced.
            lo <= div0 ? {W{1'b1}} : (neg_q ? -acc[W-1:0] : acc[W-1:0]);
            hi <= neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_ex_muldiv.sv
// Directed bench for mips_ex_muldiv: one instance at 1 bit/cycle and one at 4 bits/cycle
// share the request inputs; results, latencies, MT ops, flush and reset are checked.
module tb_mips_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst, req_valid, flush;
  logic [2:0]  req_op;
  logic [31:0] req_rs, req_rt;
  logic        ready1, busy1, done1, ready4, busy4, done4;
  logic [31:0] hi1, lo1, hi4, lo4;

  int n_vec = 0;
  int n_bad = 0;

  mips_ex_muldiv #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .flush(flush), .busy(busy1), .done(done1),
    .hi(hi1), .lo(lo1));

  mips_ex_muldiv #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready4), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .flush(flush), .busy(busy4), .done(done4),
    .hi(hi4), .lo(lo4));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one mul/div op to both instances, wait for both done pulses, check latency and HI/LO.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat1, lat4;
    lat1 = 0; lat4 = 0;
    req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt;
    tick;
    req_valid = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (done1 && lat1 == 0) lat1 = n;
      if (done4 && lat4 == 0) lat4 = n;
      if (lat1 != 0 && lat4 != 0) break;
      tick;
    end
    tick;
    check({tag, "_lat1"}, lat1, 33);
    check({tag, "_lat4"}, lat4, 9);
    check({tag, "_hilo1"}, {hi1, lo1}, {exp_hi, exp_lo});
    check({tag, "_hilo4"}, {hi4, lo4}, {exp_hi, exp_lo});
  endtask

  task automatic mt_pair(input logic [31:0] h, input logic [31:0] l);
    req_valid = 1'b1; req_op = 3'd4; req_rs = h;
    tick;
    check("mthi_nodone", done1, 0);
    req_op = 3'd5; req_rs = l;
    tick;
    req_valid = 1'b0;
    check("mt_hilo1", {hi1, lo1}, {h, l});
    check("mt_hilo4", {hi4, lo4}, {h, l});
  endtask

  initial begin
    int seen, dones;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; req_op = 3'd0; req_rs = '0; req_rt = '0;
    tick; tick;
    check("rst_hilo", {hi1, lo1}, 64'h0);
    check("rst_busy_done", {busy1, done1, busy4, done4}, 4'b0000);
    rst = 1'b0;
    tick;
    check("rst_ready", {ready1, ready4}, 2'b11);

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min2", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("multu_shift", 3'd1, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780);
    run_op("div_m7d2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu_5d0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_m7d0", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("divu_100d7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_7dm2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

    // MT ops, then an MTLO held across a MULTU 0*0 on the 1-bit instance
    mt_pair(32'h1234, 32'h5678);
    req_valid = 1'b1; req_op = 3'd1; req_rs = '0; req_rt = '0;
    tick;
    req_op = 3'd5; req_rs = 32'h9999;
    tick;
    check("mt_calc_ready", ready1, 0);
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      if (done1) begin seen = 1; break; end
      tick;
    end
    check("mt_fin_seen", seen, 1);
    check("mt_fin_lo_held", lo1, 32'h5678);
    tick;
    check("mt_commit_zero", {hi1, lo1}, 64'h0);
    tick;
    req_valid = 1'b0;
    check("mt_after_fin", {hi1, lo1}, {32'h0, 32'h9999});

    // flush in CALC cycle 10
    mt_pair(32'hA, 32'hB);
    req_valid = 1'b1; req_op = 3'd3; req_rs = 32'd100; req_rt = 32'd7;
    tick;
    req_valid = 1'b0;
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush_calc_busy", busy1, 0);
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      if (done1) dones++;
      tick;
    end
    check("flush_calc_nodone", dones, 0);
    check("flush_calc_hilo", {hi1, lo1}, {32'hA, 32'hB});

    // flush in the FIN cycle
    req_valid = 1'b1; req_op = 3'd3; req_rs = 32'd100; req_rt = 32'd7;
    tick;
    req_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      if (done1) begin seen = 1; break; end
      tick;
    end
    check("flush_fin_seen", seen, 1);
    flush = 1'b1;
    #1;
    check("flush_fin_done_low", done1, 0);
    tick;
    flush = 1'b0;
    check("flush_fin_hilo", {hi1, lo1}, {32'hA, 32'hB});
    check("flush_fin_busy", busy1, 0);
    check("flush_fin_hilo4", {hi4, lo4}, {32'd2, 32'd14});

    // flush in IDLE suppresses an MT op
    req_valid = 1'b1; req_op = 3'd4; req_rs = 32'hDEAD; flush = 1'b1;
    tick;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_mt", hi1, 32'hA);

    // reset mid-CALC
    req_valid = 1'b1; req_op = 3'd1; req_rs = 32'hFFFF_FFFF; req_rt = 32'hFFFF_FFFF;
    tick;
    req_valid = 1'b0;
    repeat (5) tick;
    check("midrst_busy_before", busy1, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_hilo", {hi1, lo1}, 64'h0);
    check("midrst_state", {busy1, ready1, done1}, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
